// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU commit-trace recorder: FSM states, capture modes
// and the packed layout of one trace record.
package cpu_trace_pkg;

  // Default record field widths; the buffer's width parameters default to these.
  localparam int unsigned TracePcW   = 32;
  localparam int unsigned TraceDataW = 32;
  localparam int unsigned TraceRegAw = 5;

  // Capture mode, sampled on arm.
  localparam logic ONE_SHOT = 1'b0;
  localparam logic CIRCULAR = 1'b1;

  // Encodings are visible on state_o and must stay fixed.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TracePcW-1:0]   pc;
    logic [TraceRegAw-1:0] rd;
    logic                  we;
    logic [TraceDataW-1:0] wdata;
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Commit tap and readout bus of the trace buffer. The master side is the CPU
// commit stage plus the debug host; the slave side is the trace buffer.
interface cpu_trace_buffer_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned AW     = 4
);

  // Commit/writeback tap
  logic              commit_valid;
  logic [PC_W-1:0]   commit_pc;
  logic [REG_AW-1:0] commit_rd;
  logic              commit_we;
  logic [DATA_W-1:0] commit_wdata;

  // Random-access readout
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [REG_AW-1:0] rd_rd;
  logic              rd_we;
  logic [DATA_W-1:0] rd_wdata;

  modport master (
    output commit_valid, commit_pc, commit_rd, commit_we, commit_wdata,
    output rd_en, rd_addr,
    input  rd_valid, rd_pc, rd_rd, rd_we, rd_wdata
  );

  modport slave (
    input  commit_valid, commit_pc, commit_rd, commit_we, commit_wdata,
    input  rd_en, rd_addr,
    output rd_valid, rd_pc, rd_rd, rd_we, rd_wdata
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 70,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when not enabled
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace recorder: captures retired instructions (PC, rd, we, wdata)
// into a DEPTH-entry buffer with optional PC trigger, one-shot or circular
// capture, and random-access readout (index 0 = oldest) once capture is done.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned PC_W   = TracePcW,
  parameter int unsigned DATA_W = TraceDataW,
  parameter int unsigned REG_AW = TraceRegAw,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic               mode_i,
  input  logic               trig_en_i,
  input  logic [PC_W-1:0]    trig_pc_i,
  input  logic               stop_i,
  cpu_trace_buffer_if.slave  bus_io,
  output logic [AW:0]        count_o,
  output logic               wrapped_o,
  output logic [1:0]         state_o
);

  localparam int unsigned RecW      = $bits(trace_rec_t);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CountLast = (AW + 1)'(DEPTH - 1);

  trace_state_e    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic            wrapped_q;
  logic            mode_q;
  logic [PC_W-1:0] trig_pc_q;
  logic            rd_valid_q;

  logic            trig_hit;
  logic            wr_en;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   rd_phys;
  logic            rd_hit;
  trace_rec_t      rec_w;
  trace_rec_t      rec_r;
  logic [RecW-1:0] ram_rdata;

  assign trig_hit = bus_io.commit_valid && (bus_io.commit_pc == trig_pc_q);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; arm overrides everything, stop only acts while armed/capturing
  always_comb begin
    state_d = state_q;
    if (arm_i) begin
      state_d = trig_en_i ? StArmed : StCapture;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StArmed: begin
          if (stop_i) begin
            state_d = StDone;
          end else if (trig_hit) begin
            state_d = StCapture;
          end
        end
        StCapture: begin
          // In one-shot mode count never reaches DEPTH while capturing, so the
          // write that fills the buffer is the one seen at DEPTH-1.
          if (stop_i || (mode_q == ONE_SHOT && bus_io.commit_valid && count_q == CountLast)) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: record write strobe and visible state
  always_comb begin
    wr_en = 1'b0;
    if (!arm_i) begin
      unique case (state_q)
        StArmed:   wr_en = trig_hit;
        StCapture: wr_en = bus_io.commit_valid;
        default:   wr_en = 1'b0;
      endcase
    end
  end

  assign state_o = state_q;

  // Capture pointer, record count, wrap flag and latched arm settings
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      mode_q    <= ONE_SHOT;
      trig_pc_q <= '0;
    end else if (arm_i) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      mode_q    <= mode_i;
      trig_pc_q <= trig_pc_i;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (count_q != CountFull) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (mode_q == CIRCULAR) begin
        wrapped_q <= 1'b1;
      end
    end
  end

  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;

  // Logical-to-physical readout index; after a wrap the oldest record sits at wr_ptr
  assign oldest  = wrapped_q ? wr_ptr_q : '0;
  assign rd_phys = oldest + bus_io.rd_addr;
  assign rd_hit  = bus_io.rd_en && (state_q == StDone) && ({1'b0, bus_io.rd_addr} < count_q);

  // Readout valid, aligned with the registered RAM read
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
    end
  end

  assign rec_w = '{
    pc:    bus_io.commit_pc,
    rd:    bus_io.commit_rd,
    we:    bus_io.commit_we,
    wdata: bus_io.commit_wdata
  };

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RecW)
  ) u_trace_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (rec_w),
    .re_i    (rd_hit),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign rec_r           = trace_rec_t'(ram_rdata);
  assign bus_io.rd_valid = rd_valid_q;
  assign bus_io.rd_pc    = rec_r.pc;
  assign bus_io.rd_rd    = rec_r.rd;
  assign bus_io.rd_we    = rec_r.we;
  assign bus_io.rd_wdata = rec_r.wdata;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=16, 32-bit PC/data).
module tb_cpu_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        arm_i;
  logic        mode_i;
  logic        trig_en_i;
  logic [31:0] trig_pc_i;
  logic        stop_i;
  logic [4:0]  count_o;
  logic        wrapped_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  cpu_trace_buffer_if #(.PC_W(32), .DATA_W(32), .REG_AW(5), .AW(4)) bus ();

  cpu_trace_buffer #(
    .PC_W   (32),
    .DATA_W (32),
    .REG_AW (5),
    .DEPTH  (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arm_i     (arm_i),
    .mode_i    (mode_i),
    .trig_en_i (trig_en_i),
    .trig_pc_i (trig_pc_i),
    .stop_i    (stop_i),
    .bus_io    (bus),
    .count_o   (count_o),
    .wrapped_o (wrapped_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; sample 1 ns after the rising edge
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    arm_i = 0; mode_i = 0; trig_en_i = 0; trig_pc_i = '0; stop_i = 0;
    bus.commit_valid = 0; bus.commit_pc = '0; bus.commit_rd = '0;
    bus.commit_we = 0; bus.commit_wdata = '0; bus.rd_en = 0; bus.rd_addr = '0;
  endtask

  task automatic do_arm(input logic mode, input logic ten, input logic [31:0] tpc);
    arm_i = 1; mode_i = mode; trig_en_i = ten; trig_pc_i = tpc;
    cycle();
    arm_i = 0;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                           input logic [31:0] wdata, input logic stop);
    bus.commit_valid = 1; bus.commit_pc = pc; bus.commit_rd = rd;
    bus.commit_we = we; bus.commit_wdata = wdata; stop_i = stop;
    cycle();
    bus.commit_valid = 0; stop_i = 0;
  endtask

  task automatic do_stop();
    stop_i = 1;
    cycle();
    stop_i = 0;
  endtask

  task automatic do_read(input logic [3:0] addr);
    bus.rd_en = 1; bus.rd_addr = addr;
    cycle();
    bus.rd_en = 0;
  endtask

  task automatic do_reset();
    rst_i = 0;
    cycle();
    cycle();
    rst_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (count_o !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (wrapped_o !== 1'b0) begin failures++; $display("FAIL reset_wrapped got=%0b exp=0", wrapped_o); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", bus.rd_valid); end
    checks++; if ({bus.rd_pc, bus.rd_rd, bus.rd_we, bus.rd_wdata} !== 70'd0) begin
      failures++; $display("FAIL reset_rd_data got pc=%0h rd=%0d we=%0b wdata=%0h exp all 0",
                           bus.rd_pc, bus.rd_rd, bus.rd_we, bus.rd_wdata);
    end
  endtask

  task automatic test_oneshot();
    do_arm(1'b0, 1'b0, 32'h0);
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL oneshot_arm_state got=%0d exp=2", state_o); end
    for (int i = 0; i < 20; i++) begin
      do_commit(32'(i * 4), 5'(i), 1'b1, 32'(i * 3), 1'b0);
      if (i == 14) begin
        checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL oneshot_state15 got=%0d exp=2", state_o); end
      end
      if (i == 15) begin
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL oneshot_state16 got=%0d exp=3", state_o); end
      end
    end
    checks++; if (count_o !== 5'd16) begin failures++; $display("FAIL oneshot_count got=%0d exp=16", count_o); end
    checks++; if (wrapped_o !== 1'b0) begin failures++; $display("FAIL oneshot_wrapped got=%0b exp=0", wrapped_o); end
    do_read(4'd0);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd0) begin
      failures++; $display("FAIL oneshot_rd0 got valid=%0b pc=%0h exp valid=1 pc=0", bus.rd_valid, bus.rd_pc);
    end
    do_read(4'd15);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd60 || bus.rd_wdata !== 32'd45) begin
      failures++; $display("FAIL oneshot_rd15 got valid=%0b pc=%0d wdata=%0d exp valid=1 pc=60 wdata=45",
                           bus.rd_valid, bus.rd_pc, bus.rd_wdata);
    end
  endtask

  task automatic test_back_to_back();
    // Buffer still holds the one-shot capture (PC = 4*addr)
    bus.rd_en = 1; bus.rd_addr = 4'd1;
    cycle();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd4) begin
      failures++; $display("FAIL b2b_rd1 got valid=%0b pc=%0d exp valid=1 pc=4", bus.rd_valid, bus.rd_pc);
    end
    bus.rd_addr = 4'd2;
    cycle();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd8 || bus.rd_rd !== 5'd2) begin
      failures++; $display("FAIL b2b_rd2 got valid=%0b pc=%0d rd=%0d exp valid=1 pc=8 rd=2",
                           bus.rd_valid, bus.rd_pc, bus.rd_rd);
    end
    bus.rd_en = 0;
  endtask

  task automatic test_circular();
    do_arm(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) do_commit(32'(i * 4), 5'(i), 1'b1, 32'(i + 100), 1'b0);
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL circ_state_run got=%0d exp=2", state_o); end
    checks++; if (count_o !== 5'd16) begin failures++; $display("FAIL circ_count got=%0d exp=16", count_o); end
    checks++; if (wrapped_o !== 1'b1) begin failures++; $display("FAIL circ_wrapped got=%0b exp=1", wrapped_o); end
    do_stop();
    checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL circ_state_stop got=%0d exp=3", state_o); end
    do_read(4'd0);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd16 || bus.rd_rd !== 5'd4) begin
      failures++; $display("FAIL circ_rd0 got valid=%0b pc=%0d rd=%0d exp valid=1 pc=16 rd=4",
                           bus.rd_valid, bus.rd_pc, bus.rd_rd);
    end
    do_read(4'd15);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'd76 || bus.rd_wdata !== 32'd119) begin
      failures++; $display("FAIL circ_rd15 got valid=%0b pc=%0d wdata=%0d exp valid=1 pc=76 wdata=119",
                           bus.rd_valid, bus.rd_pc, bus.rd_wdata);
    end
  endtask

  task automatic test_trigger();
    do_arm(1'b0, 1'b1, 32'h20);
    checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL trig_armed got=%0d exp=1", state_o); end
    for (int i = 0; i <= 16; i++) begin
      do_commit(32'(i * 4), 5'd1, 1'b1, 32'(i), 1'b0);
      if (i == 7) begin
        checks++; if (state_o !== 2'd1 || count_o !== 5'd0) begin
          failures++; $display("FAIL trig_pre got state=%0d count=%0d exp state=1 count=0", state_o, count_o);
        end
      end
      if (i == 8) begin
        checks++; if (state_o !== 2'd2 || count_o !== 5'd1) begin
          failures++; $display("FAIL trig_hit got state=%0d count=%0d exp state=2 count=1", state_o, count_o);
        end
      end
    end
    checks++; if (count_o !== 5'd9) begin failures++; $display("FAIL trig_count9 got=%0d exp=9", count_o); end
    for (int i = 17; i < 24; i++) begin
      do_commit(32'(i * 4), 5'd1, 1'b1, 32'(i), 1'b0);
      if (i == 22) begin
        checks++; if (state_o !== 2'd2 || count_o !== 5'd15) begin
          failures++; $display("FAIL trig_15 got state=%0d count=%0d exp state=2 count=15", state_o, count_o);
        end
      end
    end
    checks++; if (state_o !== 2'd3 || count_o !== 5'd16) begin
      failures++; $display("FAIL trig_done got state=%0d count=%0d exp state=3 count=16", state_o, count_o);
    end
    do_read(4'd0);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h20) begin
      failures++; $display("FAIL trig_rd0 got valid=%0b pc=%0h exp valid=1 pc=20", bus.rd_valid, bus.rd_pc);
    end
    do_read(4'd15);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h5c) begin
      failures++; $display("FAIL trig_rd15 got valid=%0b pc=%0h exp valid=1 pc=5c", bus.rd_valid, bus.rd_pc);
    end
  endtask

  task automatic test_stop_commit();
    do_arm(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) do_commit(32'(i * 4), 5'd7, 1'b0, 32'd9, 1'b0);
    do_commit(32'h0c, 5'd5, 1'b1, 32'd42, 1'b1);
    checks++; if (state_o !== 2'd3 || count_o !== 5'd4) begin
      failures++; $display("FAIL stopc_done got state=%0d count=%0d exp state=3 count=4", state_o, count_o);
    end
    do_read(4'd3);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h0c || bus.rd_rd !== 5'd5 ||
                  bus.rd_we !== 1'b1 || bus.rd_wdata !== 32'd42) begin
      failures++; $display("FAIL stopc_rd3 got valid=%0b pc=%0h rd=%0d we=%0b wdata=%0d exp 1 c 5 1 42",
                           bus.rd_valid, bus.rd_pc, bus.rd_rd, bus.rd_we, bus.rd_wdata);
    end
  endtask

  task automatic test_read_boundary();
    // DONE with count=4 from the previous scenario; last read returned PC 0x0C
    do_read(4'd4);
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'h0c) begin
      failures++; $display("FAIL bound_addr4 got valid=%0b pc=%0h exp valid=0 pc=c (held)", bus.rd_valid, bus.rd_pc);
    end
    do_arm(1'b0, 1'b0, 32'h0);
    do_commit(32'h100, 5'd1, 1'b1, 32'd1, 1'b0);
    do_read(4'd0);
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'h0c) begin
      failures++; $display("FAIL bound_capture got valid=%0b pc=%0h exp valid=0 pc=c (held)", bus.rd_valid, bus.rd_pc);
    end
  endtask

  task automatic test_armed_stop();
    do_arm(1'b0, 1'b1, 32'h999);
    do_commit(32'h4, 5'd1, 1'b1, 32'd1, 1'b0);
    do_stop();
    checks++; if (state_o !== 2'd3 || count_o !== 5'd0) begin
      failures++; $display("FAIL armstop got state=%0d count=%0d exp state=3 count=0", state_o, count_o);
    end
    do_read(4'd0);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL armstop_rd got=%0b exp=0", bus.rd_valid); end
  endtask

  task automatic test_reset_mid_capture();
    do_arm(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) do_commit(32'(i * 4), 5'd2, 1'b1, 32'd5, 1'b0);
    checks++; if (count_o !== 5'd5) begin failures++; $display("FAIL midrst_pre got=%0d exp=5", count_o); end
    do_reset();
    checks++; if (state_o !== 2'd0 || count_o !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'd0) begin
      failures++; $display("FAIL midrst got state=%0d count=%0d valid=%0b pc=%0h exp 0 0 0 0",
                           state_o, count_o, bus.rd_valid, bus.rd_pc);
    end
  endtask

  task automatic test_rearm();
    do_arm(1'b0, 1'b0, 32'h0);
    do_commit(32'h10, 5'd1, 1'b1, 32'd1, 1'b0);
    do_commit(32'h14, 5'd1, 1'b1, 32'd2, 1'b1);
    checks++; if (state_o !== 2'd3 || count_o !== 5'd2) begin
      failures++; $display("FAIL rearm_pre got state=%0d count=%0d exp state=3 count=2", state_o, count_o);
    end
    // A matching commit in the arm cycle itself must not be recorded
    bus.commit_valid = 1; bus.commit_pc = 32'h40;
    do_arm(1'b0, 1'b1, 32'h40);
    bus.commit_valid = 0;
    checks++; if (state_o !== 2'd1 || count_o !== 5'd0) begin
      failures++; $display("FAIL rearm_armed got state=%0d count=%0d exp state=1 count=0", state_o, count_o);
    end
    do_arm(1'b1, 1'b0, 32'h0);
    checks++; if (state_o !== 2'd2 || count_o !== 5'd0 || wrapped_o !== 1'b0) begin
      failures++; $display("FAIL rearm_capture got state=%0d count=%0d wrapped=%0b exp 2 0 0",
                           state_o, count_o, wrapped_o);
    end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    test_reset();
    test_oneshot();
    test_back_to_back();
    test_circular();
    test_trigger();
    test_stop_commit();
    test_read_boundary();
    test_armed_stop();
    test_reset_mid_capture();
    test_rearm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
